// File: rtl/esfa_cmd_assembler.sv
// Byte-stream framer for the ESFA 48-bit command word: header, six payload bytes,
// XOR checksum, inter-byte timeout, valid/ready hand-off.
module esfa_cmd_assembler #(
  parameter logic [7:0] HEADER_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1000,
  parameter int         CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [47:0] cmd_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        err_checksum,
  output logic        err_timeout,
  output logic [7:0]  frame_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_CHECK, ST_ISSUE} state_t;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_n;
  logic [2:0]       idx, idx_n;
  logic [7:0]       xor_acc, xor_n;
  logic [47:0]      data_n;
  logic [CNT_W-1:0] tmo_cnt, cnt_n;
  logic             ck_err_n, to_err_n;
  logic [7:0]       fc_n;
  logic             xfer;

  // Only ISSUE stalls the byte stream; every other state consumes bytes.
  assign byte_ready = (state != ST_ISSUE);
  assign cmd_valid  = (state == ST_ISSUE);
  assign xfer       = byte_valid & byte_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      idx          <= '0;
      xor_acc      <= '0;
      cmd_data     <= '0;
      tmo_cnt      <= '0;
      err_checksum <= 1'b0;
      err_timeout  <= 1'b0;
      frame_count  <= '0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      xor_acc      <= xor_n;
      cmd_data     <= data_n;
      tmo_cnt      <= cnt_n;
      err_checksum <= ck_err_n;
      err_timeout  <= to_err_n;
      frame_count  <= fc_n;
    end
  end

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    xor_n    = xor_acc;
    data_n   = cmd_data;
    cnt_n    = tmo_cnt;
    ck_err_n = 1'b0;
    to_err_n = 1'b0;
    fc_n     = frame_count;

    unique case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (xfer && byte_in == HEADER_BYTE) begin
          state_n = ST_COLLECT;
          idx_n   = '0;
          xor_n   = '0;
        end
      end

      ST_COLLECT: begin
        if (xfer) begin
          // Header value inside the payload is plain data; no resync.
          data_n[{idx, 3'b000} +: 8] = byte_in;
          xor_n = xor_acc ^ byte_in;
          cnt_n = '0;
          if (idx == 3'd5) state_n = ST_CHECK;
          else             idx_n   = idx + 3'd1;
        end else if (tmo_cnt == TMO_LAST) begin
          to_err_n = 1'b1;
          cnt_n    = '0;
          state_n  = ST_IDLE;
        end else begin
          cnt_n = tmo_cnt + 1'b1;
        end
      end

      ST_CHECK: begin
        if (xfer) begin
          cnt_n = '0;
          if (byte_in == xor_acc) begin
            state_n = ST_ISSUE;
          end else begin
            ck_err_n = 1'b1;
            state_n  = ST_IDLE;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          to_err_n = 1'b1;
          cnt_n    = '0;
          state_n  = ST_IDLE;
        end else begin
          cnt_n = tmo_cnt + 1'b1;
        end
      end

      ST_ISSUE: begin
        // No timeout here: the command waits for the consumer indefinitely.
        if (cmd_ready) begin
          fc_n    = frame_count + 8'd1;
          state_n = ST_IDLE;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_esfa_cmd_assembler.sv
// Directed bench for esfa_cmd_assembler with TIMEOUT_CYCLES=8.
module tb_esfa_cmd_assembler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [47:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic        err_checksum;
  logic        err_timeout;
  logic [7:0]  frame_count;

  int total = 0;
  int bad   = 0;
  int ck_pulses = 0;
  int to_pulses = 0;
  int both_pulses = 0;

  localparam logic [47:0] NOM_DATA  = 48'h0500002A0301;
  localparam logic [63:0] NOM_FRAME = 64'hA501032A0000052D;

  esfa_cmd_assembler #(
    .HEADER_BYTE(8'hA5), .TIMEOUT_CYCLES(8), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .err_checksum(err_checksum), .err_timeout(err_timeout),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (err_checksum) ck_pulses++;
      if (err_timeout)  to_pulses++;
      if (err_checksum && err_timeout) both_pulses++;
    end
  end

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    byte_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Sends the first n bytes of v, most significant byte first, back-to-back.
  task automatic send_seq(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      byte_in    = v[63-8*i -: 8];
      byte_valid = 1'b1;
      tick();
    end
    byte_valid = 1'b0;
  endtask

  task automatic check_post_reset(input string tag);
    chk({tag, "_valid"}, {47'd0, cmd_valid}, 48'd0);
    chk({tag, "_data"},  cmd_data, 48'd0);
    chk({tag, "_fc"},    {40'd0, frame_count}, 48'd0);
    chk({tag, "_rdy"},   {47'd0, byte_ready}, 48'd1);
  endtask

  initial begin
    do_reset();
    check_post_reset("rst");
    chk("rst_errck", {47'd0, err_checksum}, 48'd0);
    chk("rst_errto", {47'd0, err_timeout}, 48'd0);

    // Nominal frame, consumer ready.
    cmd_ready = 1'b1;
    send_seq(NOM_FRAME, 8);
    chk("nom_valid", {47'd0, cmd_valid}, 48'd1);
    chk("nom_data", cmd_data, NOM_DATA);
    tick();
    chk("nom_valid_drop", {47'd0, cmd_valid}, 48'd0);
    chk("nom_fc", {40'd0, frame_count}, 48'd1);
    chk("nom_rdy", {47'd0, byte_ready}, 48'd1);

    // Backpressure for 10 cycles with a stray byte offered.
    do_reset();
    cmd_ready = 1'b0;
    send_seq(NOM_FRAME, 8);
    byte_in = 8'hA5;
    byte_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", {47'd0, cmd_valid}, 48'd1);
      chk("bp_data", cmd_data, NOM_DATA);
      chk("bp_rdy", {47'd0, byte_ready}, 48'd0);
      tick();
    end
    byte_valid = 1'b0;
    cmd_ready = 1'b1;
    tick();
    chk("bp_valid_drop", {47'd0, cmd_valid}, 48'd0);
    chk("bp_fc", {40'd0, frame_count}, 48'd1);
    chk("bp_rdy", {47'd0, byte_ready}, 48'd1);

    // Checksum error, then a good frame.
    send_seq(64'hA501032A0000052C, 8);
    chk("ck_pulse", {47'd0, err_checksum}, 48'd1);
    chk("ck_valid", {47'd0, cmd_valid}, 48'd0);
    tick();
    chk("ck_pulse_end", {47'd0, err_checksum}, 48'd0);
    chk("ck_valid2", {47'd0, cmd_valid}, 48'd0);
    chk("ck_fc", {40'd0, frame_count}, 48'd1);
    send_seq(NOM_FRAME, 8);
    chk("ck_next_valid", {47'd0, cmd_valid}, 48'd1);
    chk("ck_next_data", cmd_data, NOM_DATA);
    tick();
    chk("ck_next_fc", {40'd0, frame_count}, 48'd2);

    // Timeout: 8 idle cycles after the last accepted byte.
    send_seq(64'hA501030000000000, 3);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("to_pulse", {47'd0, err_timeout}, (k == 8) ? 48'd1 : 48'd0);
    end
    tick();
    chk("to_pulse_end", {47'd0, err_timeout}, 48'd0);
    send_seq(NOM_FRAME, 8);
    chk("to_next_valid", {47'd0, cmd_valid}, 48'd1);
    chk("to_next_data", cmd_data, NOM_DATA);
    tick();
    chk("to_next_fc", {40'd0, frame_count}, 48'd3);

    // Byte arriving in the limit cycle wins.
    send_seq(64'hA501030000000000, 3);
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("edge_noto", {47'd0, err_timeout}, 48'd0);
    end
    send_seq(64'h2A0000052D000000, 5);
    chk("edge_valid", {47'd0, cmd_valid}, 48'd1);
    chk("edge_data", cmd_data, NOM_DATA);
    chk("edge_noto2", {47'd0, err_timeout}, 48'd0);
    tick();
    chk("edge_fc", {40'd0, frame_count}, 48'd4);

    // Leading noise and header value inside the payload.
    send_seq(64'h1122A5A5A5000000, 8);
    send_seq(64'h0000000000000000, 2);
    chk("hdr_valid", {47'd0, cmd_valid}, 48'd1);
    chk("hdr_data", cmd_data, 48'h00000000A5A5);
    tick();
    chk("hdr_fc", {40'd0, frame_count}, 48'd5);

    // Reset mid-frame.
    send_seq(64'hA501032A00000000, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_post_reset("rstmid");
    send_seq(NOM_FRAME, 8);
    chk("rstmid_valid", {47'd0, cmd_valid}, 48'd1);
    chk("rstmid_data", cmd_data, NOM_DATA);
    tick();
    chk("rstmid_fc", {40'd0, frame_count}, 48'd1);

    // Reset while a command is waiting.
    cmd_ready = 1'b0;
    send_seq(NOM_FRAME, 8);
    chk("rstiss_pre", {47'd0, cmd_valid}, 48'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_post_reset("rstiss");
    cmd_ready = 1'b1;
    send_seq(NOM_FRAME, 8);
    chk("rstiss_valid", {47'd0, cmd_valid}, 48'd1);
    chk("rstiss_data", cmd_data, NOM_DATA);
    tick();
    chk("rstiss_fc", {40'd0, frame_count}, 48'd1);

    tick();
    chk("ck_pulse_cnt", 48'(ck_pulses), 48'd1);
    chk("to_pulse_cnt", 48'(to_pulses), 48'd1);
    chk("both_pulse_cnt", 48'(both_pulses), 48'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
